// File: rtl/arb_pkg.sv
// Shared types and defaults for the request arbiter.
//   state_t      : grant FSM encoding (IDLE, GRANT, GAP)
//   STATE_W      : width of state_t
//   DEF_N        : default number of requesters
//   DEF_MAX_HOLD : default hold-time limit before preemption
package arb_pkg;

    localparam int STATE_W      = 2;
    localparam int DEF_N        = 4;
    localparam int DEF_MAX_HOLD = 8;

    typedef enum logic [STATE_W-1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        GAP   = 2'd2
    } state_t;

endpackage

// File: rtl/req_arbiter_if.sv
// Request/grant bundle between requester blocks and the arbiter.
//   req     : request vector, bit i owned by requester i
//   gnt     : registered one-hot grant
//   gnt_idx : binary index of the owner (valid with gnt_vld)
//   gnt_vld : a grant is active
//   preempt : one-cycle pulse when a grant is ended by the hold limit
// modport master: requester side; modport slave: arbiter side.
interface req_arbiter_if
    import arb_pkg::*;
#(
    parameter int N  = DEF_N,
    parameter int IW = $clog2(N)
);
    logic [N-1:0]  req;
    logic [N-1:0]  gnt;
    logic [IW-1:0] gnt_idx;
    logic          gnt_vld;
    logic          preempt;

    modport master (output req, input gnt, input gnt_idx, input gnt_vld, input preempt);
    modport slave  (input req, output gnt, output gnt_idx, output gnt_vld, output preempt);
endinterface

// File: rtl/req_arbiter_prio_sel.sv
// Combinational N-bit priority selector.
//   req_i    : candidate request vector
//   start_i  : first index scanned in round-robin mode
//   rr_i     : 1 = round-robin scan from start_i with wrap, 0 = highest index wins
//   found_o  : at least one request set
//   idx_o    : selected index
//   onehot_o : selected index as one-hot (zero when nothing found)
module prio_sel #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] start_i,
    input  logic          rr_i,
    output logic          found_o,
    output logic [IW-1:0] idx_o,
    output logic [N-1:0]  onehot_o
);

    int pos;

    always_comb begin
        found_o  = 1'b0;
        idx_o    = '0;
        onehot_o = '0;
        pos      = 0;
        if (rr_i) begin
            // Scan from the farthest offset back to start_i so the nearest hit is written last.
            for (int k = N - 1; k >= 0; k--) begin
                pos = (int'(start_i) + k) % N;
                if (req_i[IW'(pos)]) begin
                    found_o = 1'b1;
                    idx_o   = IW'(pos);
                end
            end
        end else begin
            for (int i = 0; i < N; i++) begin
                if (req_i[IW'(i)]) begin
                    found_o = 1'b1;
                    idx_o   = IW'(i);
                end
            end
        end
        if (found_o) onehot_o[idx_o] = 1'b1;
    end

endmodule

// File: rtl/req_arbiter.sv
// Sequential arbiter sharing one downstream resource between N requesters.
//   clk     : rising-edge clock
//   rst_n   : synchronous active-low reset
//   bus     : slave side of req_arbiter_if (req in; gnt, gnt_idx, gnt_vld, preempt out)
// Parameters: N requesters, RR (1 round-robin / 0 fixed highest-index),
// MAX_HOLD consecutive grant cycles before forced release when others wait.
//
// state | meaning
// IDLE  | no owner, arbitrate on every edge
// GRANT | one owner holds the resource, hold counter running
// GAP   | single turnaround cycle with gnt=0, then arbitrate like IDLE
module req_arbiter
    import arb_pkg::*;
#(
    parameter int N        = DEF_N,
    parameter int RR       = 1,
    parameter int MAX_HOLD = DEF_MAX_HOLD,
    parameter int IW       = $clog2(N)
) (
    input  logic          clk,
    input  logic          rst_n,
    req_arbiter_if.slave  bus
);

    localparam int   CW      = $clog2(MAX_HOLD + 1);
    localparam logic RR_MODE = (RR != 0);

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [IW-1:0] last_q, last_d;
    logic [N-1:0]  gnt_q, gnt_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          vld_q, vld_d;
    logic          pre_q, pre_d;

    logic [IW-1:0] start;
    logic          sel_found;
    logic [IW-1:0] sel_idx;
    logic [N-1:0]  sel_oh;
    logic          owner_req;
    logic          others_wait;

    assign start       = (last_q == IW'(N - 1)) ? '0 : last_q + 1'b1;
    assign owner_req   = |(bus.req & gnt_q);
    assign others_wait = |(bus.req & ~gnt_q);

    prio_sel #(.N(N), .IW(IW)) u_sel (
        .req_i    (bus.req),
        .start_i  (start),
        .rr_i     (RR_MODE),
        .found_o  (sel_found),
        .idx_o    (sel_idx),
        .onehot_o (sel_oh)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        gnt_d   = gnt_q;
        idx_d   = idx_q;
        vld_d   = vld_q;
        pre_d   = 1'b0;
        case (state_q)
            GRANT: begin
                if (!owner_req) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                end else if (cnt_q == CW'(MAX_HOLD) && others_wait) begin
                    state_d = GAP;
                    gnt_d   = '0;
                    vld_d   = 1'b0;
                    pre_d   = 1'b1;
                end else if (cnt_q != CW'(MAX_HOLD)) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: begin
                // IDLE and GAP arbitrate identically; idx is held when nothing is granted.
                gnt_d   = '0;
                vld_d   = 1'b0;
                state_d = IDLE;
                if (sel_found) begin
                    state_d = GRANT;
                    gnt_d   = sel_oh;
                    idx_d   = sel_idx;
                    vld_d   = 1'b1;
                    last_d  = sel_idx;
                    cnt_d   = CW'(1);
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            last_q  <= IW'(N - 1);
            gnt_q   <= '0;
            idx_q   <= '0;
            vld_q   <= 1'b0;
            pre_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            last_q  <= last_d;
            gnt_q   <= gnt_d;
            idx_q   <= idx_d;
            vld_q   <= vld_d;
            pre_q   <= pre_d;
        end
    end

    assign bus.gnt     = gnt_q;
    assign bus.gnt_idx = idx_q;
    assign bus.gnt_vld = vld_q;
    assign bus.preempt = pre_q;

endmodule
